// File: rtl/pll_pkg.sv
// Shared PLL definitions: default error width, phase-detector state encoding
// and the signed magnitude limit helper.
package pll_pkg;

   localparam int unsigned ERR_W = 16;

   typedef enum logic [1:0] {
      PD_IDLE     = 2'd0,
      PD_WAIT_FB  = 2'd1,
      PD_WAIT_REF = 2'd2
   } pd_state_t;

   // Largest symmetric magnitude of a signed w-bit value: 2^(w-1)-1.
   function automatic int unsigned pd_maxe(input int unsigned w);
      return (32'd1 << (w - 32'd1)) - 32'd1;
   endfunction

endpackage

// File: rtl/phase_detector_if.sv
// Phase detector pin/measurement bundle; master drives the pins, slave is the detector.
interface phase_detector_if #(
   parameter int unsigned ERR_W = pll_pkg::ERR_W
);
   logic                    ena;
   logic                    ref_in;
   logic                    fb_in;
   logic                    phase_valid;
   logic signed [ERR_W-1:0] phase_err;
   logic                    lock;

   modport master (
      output ena, ref_in, fb_in,
      input  phase_valid, phase_err, lock
   );

   modport slave (
      input  ena, ref_in, fb_in,
      output phase_valid, phase_err, lock
   );
endinterface

// File: rtl/phase_detector_edge_sync.sv
// Multi-stage synchronizer with rising-edge detector; edges are suppressed while
// the post-reset warm-up counter drains so a pin held high through reset is ignored.
module edge_sync
   import pll_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_c
);

   localparam int unsigned WU_W = $clog2(STAGES + 2);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic [WU_W-1:0]   warm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         warm_q <= WU_W'(STAGES + 1);
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
         if (warm_q != '0) begin
            warm_q <= warm_q - WU_W'(1);
         end
      end
   end

   assign rise_c = sync_q[STAGES-1] & ~prev_q & (warm_q == '0);

endmodule

// File: rtl/phase_detector.sv
// Counter-based phase/frequency detector: measures ref/fb rising-edge spacing in clk
// cycles, emits a saturated signed error with a strobe and tracks loop lock.
module phase_detector
   import pll_pkg::*;
#(
   parameter int unsigned ERR_W       = pll_pkg::ERR_W,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_TOL    = 4,
   parameter int unsigned LOCK_N      = 8
) (
   input logic             clk,
   input logic             rst,
   phase_detector_if.slave pd
);

   localparam int unsigned CNT_W = ERR_W - 1;
   localparam int unsigned LC_W  = $clog2(LOCK_N + 1);
   localparam logic [CNT_W-1:0] MAXE = CNT_W'(pd_maxe(ERR_W));

   logic ref_e_c;
   logic fb_e_c;

   edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (pd.ref_in),
      .rise_c  (ref_e_c)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_fb_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (pd.fb_in),
      .rise_c  (fb_e_c)
   );

   pd_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic             lock_q, lock_d;

   logic             emit;
   logic             emit_neg;
   logic [CNT_W-1:0] emit_mag;
   logic [CNT_W-1:0] cnt_inc;
   logic [ERR_W-1:0] mag_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PD_IDLE;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         err_q      <= '0;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
      end
   end

   // Measurement FSM; WAIT_REF mirrors WAIT_FB with the edges swapped and sign negated.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      err_d      = err_q;
      lock_cnt_d = lock_cnt_q;
      lock_d     = lock_q;
      emit       = 1'b0;
      emit_neg   = 1'b0;
      emit_mag   = '0;
      cnt_inc    = cnt_q + CNT_W'(1);
      mag_ext    = '0;

      if (!pd.ena) begin
         state_d    = PD_IDLE;
         cnt_d      = '0;
         lock_cnt_d = '0;
         lock_d     = 1'b0;
      end else begin
         case (state_q)
            PD_IDLE: begin
               if (ref_e_c && fb_e_c) begin
                  emit = 1'b1;
               end else if (ref_e_c) begin
                  state_d = PD_WAIT_FB;
                  cnt_d   = CNT_W'(1);
               end else if (fb_e_c) begin
                  state_d = PD_WAIT_REF;
                  cnt_d   = CNT_W'(1);
               end
            end

            PD_WAIT_FB: begin
               if (fb_e_c) begin
                  emit     = 1'b1;
                  emit_mag = cnt_q;
                  if (ref_e_c) begin
                     cnt_d = CNT_W'(1);
                  end else begin
                     state_d = PD_IDLE;
                     cnt_d   = '0;
                  end
               end else if (ref_e_c) begin
                  emit     = 1'b1;
                  emit_mag = MAXE;
                  cnt_d    = CNT_W'(1);
               end else if (cnt_inc == MAXE) begin
                  emit     = 1'b1;
                  emit_mag = MAXE;
                  state_d  = PD_IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            PD_WAIT_REF: begin
               emit_neg = 1'b1;
               if (ref_e_c) begin
                  emit     = 1'b1;
                  emit_mag = cnt_q;
                  if (fb_e_c) begin
                     cnt_d = CNT_W'(1);
                  end else begin
                     state_d = PD_IDLE;
                     cnt_d   = '0;
                  end
               end else if (fb_e_c) begin
                  emit     = 1'b1;
                  emit_mag = MAXE;
                  cnt_d    = CNT_W'(1);
               end else if (cnt_inc == MAXE) begin
                  emit     = 1'b1;
                  emit_mag = MAXE;
                  state_d  = PD_IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            default: begin
               state_d = PD_IDLE;
               cnt_d   = '0;
            end
         endcase

         // Magnitude never exceeds MAXE, so negation cannot reach -2^(ERR_W-1).
         if (emit) begin
            valid_d = 1'b1;
            mag_ext = {1'b0, emit_mag};
            err_d   = emit_neg ? (~mag_ext + ERR_W'(1)) : mag_ext;
            if (emit_mag <= CNT_W'(LOCK_TOL)) begin
               if (lock_cnt_q != LC_W'(LOCK_N)) begin
                  lock_cnt_d = lock_cnt_q + LC_W'(1);
               end
               lock_d = (lock_cnt_d == LC_W'(LOCK_N));
            end else begin
               lock_cnt_d = '0;
               lock_d     = 1'b0;
            end
         end
      end
   end

   assign pd.phase_valid = valid_q;
   assign pd.phase_err   = err_q;
   assign pd.lock        = lock_q;

endmodule
